// File: rtl/autosym_restr_eval_if.sv
// Config, input-stream and output-stream signals of the autosymmetric evaluator.
// The slave modport is the evaluator side; master is the driver side.
interface autosym_restr_eval_if #(
  parameter int N_IN  = 9,
  parameter int K_RES = 7,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
);
  localparam int CFG_W = (N_IN > N_OUT) ? N_IN : N_OUT;

  logic             cfg_start;
  logic             cfg_done;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [K_RES-1:0] cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_mode;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_y;
  logic [CNT_W-1:0] res_count;

  modport slave (
    input  cfg_start, cfg_done, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_valid, in_x, out_ready,
    output cfg_mode, in_ready, out_valid, out_y, res_count
  );

  modport master (
    output cfg_start, cfg_done, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_valid, in_x, out_ready,
    input  cfg_mode, in_ready, out_valid, out_y, res_count
  );
endinterface

// File: rtl/autosym_restr_eval.sv
// Streaming evaluator: y = A*x ^ c over GF(2), then out = tab[y].
// One row sub-module per restriction variable holds its row of A and forms y[i].
module autosym_restr_row #(
  parameter int N_IN = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [N_IN-1:0] wdata,
  input  logic [N_IN-1:0] x,
  input  logic            c_bit,
  output logic            y_bit
);
  logic [N_IN-1:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  row <= '0;
    else if (we) row <= wdata;
  end

  assign y_bit = (^(row & x)) ^ c_bit;
endmodule

module autosym_restr_eval #(
  parameter int N_IN  = 9,
  parameter int K_RES = 7,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  autosym_restr_eval_if.slave  bus
);
  localparam int CFG_W  = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int CW     = (K_RES < CFG_W) ? K_RES : CFG_W;
  localparam int DEPTH  = 2**K_RES;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_CFG = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                       state, state_nxt;
  logic [STAGES:1]              vld_pipe;
  logic                         adv, acc, cfg_wr, pipe_empty;
  logic [K_RES-1:0]             row_we;
  logic [K_RES-1:0]             c_reg, c_wdata, y_comb, s1_y;
  logic [DEPTH-1:0][N_OUT-1:0]  tab;
  logic [N_OUT-1:0]             out_y_q;
  logic [CNT_W-1:0]             cnt;

  assign adv        = !vld_pipe[STAGES] || bus.out_ready;
  assign acc        = bus.in_valid && bus.in_ready;
  assign cfg_wr     = (state == S_CFG) && bus.cfg_we;
  assign pipe_empty = (vld_pipe == '0);

  assign bus.in_ready  = (state == S_RUN) && adv;
  assign bus.cfg_mode  = (state == S_CFG);
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_y     = out_y_q;
  assign bus.res_count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CFG;
    else        state <= state_nxt;
  end

  // A vector accepted in the same cycle as cfg_start still counts as in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CFG:   if (bus.cfg_done)  state_nxt = S_RUN;
      S_RUN:   if (bus.cfg_start) state_nxt = (pipe_empty && !acc) ? S_CFG : S_DRAIN;
      S_DRAIN: if (pipe_empty)    state_nxt = S_CFG;
      default: state_nxt = S_CFG;
    endcase
  end

  for (genvar i = 0; i < K_RES; i++) begin : g_row
    assign row_we[i] = cfg_wr && (bus.cfg_sel == 2'b00) && (bus.cfg_addr == K_RES'(i));
    autosym_restr_row #(.N_IN(N_IN)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (row_we[i]),
      .wdata (bus.cfg_data[N_IN-1:0]),
      .x     (bus.in_x),
      .c_bit (c_reg[i]),
      .y_bit (y_comb[i])
    );
  end

  always_comb begin
    c_wdata         = '0;
    c_wdata[CW-1:0] = bus.cfg_data[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= '0;
      tab   <= '0;
    end else if (cfg_wr) begin
      unique case (bus.cfg_sel)
        2'b01:   c_reg <= c_wdata;
        2'b10:   tab[bus.cfg_addr] <= bus.cfg_data[N_OUT-1:0];
        default: ;
      endcase
    end
  end

  // Both stages advance together; a full S2 with out_ready low freezes the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_y     <= '0;
      out_y_q  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      if (acc)         s1_y    <= y_comb;
      if (vld_pipe[1]) out_y_q <= tab[s1_y];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              cnt <= '0;
    else if (bus.out_valid && bus.out_ready && cnt != '1)    cnt <= cnt + 1'b1;
  end
endmodule
